vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 640x480 sync block.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator.
// Holds the mode presets (640x480@60 and 800x600@60), the helpers that
// compute line and frame totals, and the region type that names the
// position within one axis.
// The optional fetch lookahead ports are enabled with the
// VGA_TIMING_LOOKAHEAD_EN macro, which is handled in vga_timing_gen.
package vga_timing_pkg;

  // Order of the regions along each axis: visible area, front porch, sync, back porch.
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } region_t;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a counter that wraps at ACTIVE+FP+SYNC+BP-1 and
// reports which region the current count lies in.
// Ports:
//   clk, clr  clock; asynchronous active-high reset (count returns to 0)
//   cin       advance enable (pixel tick for H, line wrap for V)
//   cnt       current position, 0..TOTAL-1
//   cout      high when cin is high and the count is about to wrap
//   region    region of cnt (active, front porch, sync, back porch)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cin,
  output logic [W-1:0] cnt,
  output logic         cout,
  output region_t      region
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL - 1 >= (1 << W)) begin : g_width_check
    $error("vga_axis_counter: TOTAL-1 does not fit in W bits");
  end

  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] A_END = W'(ACTIVE);
  localparam logic [W-1:0] F_END = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC);

  assign cout = cin && (cnt == LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (cin) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  always_comb begin
    region = REG_BP;
    if (cnt < A_END)      region = REG_ACTIVE;
    else if (cnt < F_END) region = REG_FP;
    else if (cnt < S_END) region = REG_SYNC;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// A pixel-clock divider produces pix_tick; on each tick the registered
// outputs take the decode of the internal next-position counter (h,v),
// which then advances. All registered outputs therefore describe the same
// pixel and change on the clk following the tick.
// Ports:
//   clk, clr      system clock; asynchronous active-high reset
//   en            run enable; low freezes divider, counters and outputs
//   pix_tick      one-clk pulse per pixel period
//   hsync, vsync  sync outputs, level HS_POL / VS_POL when asserted
//   vidon         (hc,vc) lies in the visible area
//   hc, vc        raster position of the current pixel
//   line_start    one-clk pulse when hc becomes 0
//   frame_start   one-clk pulse when (hc,vc) becomes (0,0)
//   fetch_x/y, fetch_vld  position LEAD ticks ahead and its visibility;
//                 present only when VGA_TIMING_LOOKAHEAD_EN is defined
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 1,
  parameter int LEAD     = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             vidon,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  output logic             fetch_vld
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h, v;
  logic             h_wrap, v_wrap;
  region_t          h_reg, v_reg;
  // Set when the next tick loads column 0 / position (0,0); both start set
  // so the first tick after reset raises both strobes.
  logic             line_pend, frame_pend;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  // Gated by clr so the tick reads 0 throughout reset even when CLK_DIV=1.
  assign pix_tick = en & ~clr & (div == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h (
    .clk(clk), .clr(clr), .cin(pix_tick), .cnt(h), .cout(h_wrap), .region(h_reg)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v (
    .clk(clk), .clr(clr), .cin(h_wrap), .cnt(v), .cout(v_wrap), .region(v_reg)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      vidon       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_pend   <= 1'b1;
      frame_pend  <= 1'b1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_tick) begin
        hc          <= h;
        vc          <= v;
        vidon       <= (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
        hsync       <= (h_reg == REG_SYNC) ? HS_POL : ~HS_POL;
        vsync       <= (v_reg == REG_SYNC) ? VS_POL : ~VS_POL;
        line_start  <= line_pend;
        frame_start <= frame_pend;
        line_pend   <= h_wrap;
        frame_pend  <= v_wrap;
      end
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  if (LEAD < 1 || LEAD >= H_TOTAL) begin : g_lead_check
    $error("vga_timing_gen: LEAD must satisfy 1 <= LEAD < H_TOTAL");
  end

  localparam logic [CNT_W:0]   HT_S   = (CNT_W + 1)'(H_TOTAL);
  localparam logic [CNT_W:0]   LEAD_S = (CNT_W + 1)'(LEAD);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HA_S   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_S   = CNT_W'(V_ACTIVE);

  logic [CNT_W:0]   h_sum;
  logic             h_carry;
  logic [CNT_W-1:0] fx, fy;

  // LEAD < H_TOTAL, so the lookahead crosses at most one line boundary.
  always_comb begin
    h_sum   = {1'b0, h} + LEAD_S;
    h_carry = (h_sum >= HT_S);
    fx      = CNT_W'(h_carry ? (h_sum - HT_S) : h_sum);
    fy      = v;
    if (h_carry) fy = (v == V_LAST) ? '0 : v + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_x   <= '0;
      fetch_y   <= '0;
      fetch_vld <= 1'b0;
    end else if (pix_tick) begin
      fetch_x   <= fx;
      fetch_y   <= fy;
      fetch_vld <= (fx < HA_S) && (fy < VA_S);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int N = 4;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div, hpol, vpol, lead;
  } mode_t;

  typedef struct packed {
    int hc; int vc; int hs; int vs; int vid; int ls; int fs; int fx; int fy; int fv;
  } obs_t;

  typedef struct {
    int adv; int hc; int vc; int hs; int vs; int vid; int ls; int fs;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic en[N];

  wire [N-1:0] tk, hs, vs, vid, ls, fs;
  wire [9:0]  hc0, vc0;
  wire [4:0]  hc1, vc1;
  wire [10:0] hc2, vc2;
  wire [3:0]  hc3, vc3;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  wire [9:0]  fx0, fy0;
  wire [4:0]  fx1, fy1;
  wire [10:0] fx2, fy2;
  wire [3:0]  fx3, fy3;
  wire [N-1:0] fv;
`endif

  mode_t md[N];
  int ecnt[N], nt[N];
  bit jt[N];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // u0: default 640x480, CLK_DIV=1, LEAD=2
  vga_timing_gen u0 (
    .clk(clk), .clr(clr), .en(en[0]), .pix_tick(tk[0]), .hsync(hs[0]), .vsync(vs[0]),
    .vidon(vid[0]), .hc(hc0), .vc(vc0), .line_start(ls[0]), .frame_start(fs[0])
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_x(fx0), .fetch_y(fy0), .fetch_vld(fv[0])
`endif
  );

  // u1: tiny mode, positive syncs, CLK_DIV=3
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(5), .CLK_DIV(3), .LEAD(3)
  ) u1 (
    .clk(clk), .clr(clr), .en(en[1]), .pix_tick(tk[1]), .hsync(hs[1]), .vsync(vs[1]),
    .vidon(vid[1]), .hc(hc1), .vc(vc1), .line_start(ls[1]), .frame_start(fs[1])
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_x(fx1), .fetch_y(fy1), .fetch_vld(fv[1])
`endif
  );

  // u2: 800x600 preset, positive syncs, CLK_DIV=4
  vga_timing_gen #(
    .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
    .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP), .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
    .HS_POL(SVGA800_HS_POL), .VS_POL(SVGA800_VS_POL), .CNT_W(11), .CLK_DIV(4), .LEAD(2)
  ) u2 (
    .clk(clk), .clr(clr), .en(en[2]), .pix_tick(tk[2]), .hsync(hs[2]), .vsync(vs[2]),
    .vidon(vid[2]), .hc(hc2), .vc(vc2), .line_start(ls[2]), .frame_start(fs[2])
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_x(fx2), .fetch_y(fy2), .fetch_vld(fv[2])
`endif
  );

  // u3: tiny mode, negative syncs, CLK_DIV=2, maximum lead
  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .CLK_DIV(2), .LEAD(9)
  ) u3 (
    .clk(clk), .clr(clr), .en(en[3]), .pix_tick(tk[3]), .hsync(hs[3]), .vsync(vs[3]),
    .vidon(vid[3]), .hc(hc3), .vc(vc3), .line_start(ls[3]), .frame_start(fs[3])
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .fetch_x(fx3), .fetch_y(fy3), .fetch_vld(fv[3])
`endif
  );

  function automatic obs_t sample(input int i);
    obs_t o;
    o = '0;
    o.hs  = int'(hs[i]);
    o.vs  = int'(vs[i]);
    o.vid = int'(vid[i]);
    o.ls  = int'(ls[i]);
    o.fs  = int'(fs[i]);
    case (i)
      0: begin o.hc = int'(hc0); o.vc = int'(vc0); end
      1: begin o.hc = int'(hc1); o.vc = int'(vc1); end
      2: begin o.hc = int'(hc2); o.vc = int'(vc2); end
      default: begin o.hc = int'(hc3); o.vc = int'(vc3); end
    endcase
`ifdef VGA_TIMING_LOOKAHEAD_EN
    o.fv = int'(fv[i]);
    case (i)
      0: begin o.fx = int'(fx0); o.fy = int'(fy0); end
      1: begin o.fx = int'(fx1); o.fy = int'(fy1); end
      2: begin o.fx = int'(fx2); o.fy = int'(fy2); end
      default: begin o.fx = int'(fx3); o.fy = int'(fy3); end
    endcase
`endif
    return o;
  endfunction

  // Reference: after n ticks the outputs show pixel number n-1 of the
  // frame in raster order; the sync/visible decision is plain range tests.
  function automatic obs_t expect_obs(input int i);
    obs_t o;
    mode_t m;
    int ht, vt, p, q;
    m  = md[i];
    o  = '0;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    if (nt[i] == 0) begin
      o.hs = 1 - m.hpol;
      o.vs = 1 - m.vpol;
      return o;
    end
    p    = (nt[i] - 1) % (ht * vt);
    o.hc = p % ht;
    o.vc = p / ht;
    o.vid = (o.hc < m.ha && o.vc < m.va) ? 1 : 0;
    o.hs = (o.hc >= m.ha + m.hf && o.hc < m.ha + m.hf + m.hs) ? m.hpol : 1 - m.hpol;
    o.vs = (o.vc >= m.va + m.vf && o.vc < m.va + m.vf + m.vs) ? m.vpol : 1 - m.vpol;
    o.ls = (jt[i] && o.hc == 0) ? 1 : 0;
    o.fs = (jt[i] && p == 0) ? 1 : 0;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    q    = (p + m.lead) % (ht * vt);
    o.fx = q % ht;
    o.fy = q / ht;
    o.fv = (o.fx < m.ha && o.fy < m.va) ? 1 : 0;
`else
    q = 0;
`endif
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hc=%0d vc=%0d hs=%0d vs=%0d vid=%0d ls=%0d fs=%0d fetch=(%0d,%0d,%0d)",
                     o.hc, o.vc, o.hs, o.vs, o.vid, o.ls, o.fs, o.fx, o.fy, o.fv);
  endfunction

  task automatic check_obs(input string name, input int i, input obs_t a, input obs_t e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s u%0d: got %s want %s", name, i, fmt(a), fmt(e));
    end
  endtask

  task automatic check_int(input string name, input int i, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s u%0d: got %0d want %0d", name, i, a, e);
    end
  endtask

  // One clock: inputs applied at the falling edge, tick checked just after,
  // registered outputs checked at the next falling edge.
  task automatic step(input bit c, input bit [N-1:0] e);
    bit te[N];
    clr = c;
    for (int i = 0; i < N; i++) en[i] = e[i];
    if (c) begin
      for (int i = 0; i < N; i++) begin
        nt[i] = 0; ecnt[i] = 0; jt[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      te[i] = !c && e[i] && (ecnt[i] % md[i].div == md[i].div - 1);
      check_int("pix_tick", i, int'(tk[i]), te[i] ? 1 : 0);
      if (c) check_obs("clr_async", i, sample(i), expect_obs(i));
    end
    @(posedge clk);
    if (!c) begin
      for (int i = 0; i < N; i++) begin
        jt[i] = te[i];
        if (te[i]) nt[i]++;
        if (e[i]) ecnt[i]++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) check_obs("outputs", i, sample(i), expect_obs(i));
  endtask

  vec_t tbl[10];

  initial begin
    obs_t a;
    int guard;
    bit [N-1:0] er;

    md[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 0, 2};
    md[1] = '{8, 2, 3, 2, 5, 1, 2, 2, 3, 1, 1, 3};
    md[2] = '{SVGA800_H_ACTIVE, SVGA800_H_FP, SVGA800_H_SYNC, SVGA800_H_BP,
              SVGA800_V_ACTIVE, SVGA800_V_FP, SVGA800_V_SYNC, SVGA800_V_BP, 4, 1, 1, 2};
    md[3] = '{6, 1, 2, 1, 4, 1, 1, 2, 2, 0, 0, 9};

    // {ticks to advance, hc, vc, hsync, vsync, vidon, line_start, frame_start} for u0
    tbl[0] = '{1,   0,   0, 1, 1, 1, 1, 1};
    tbl[1] = '{639, 639, 0, 1, 1, 1, 0, 0};
    tbl[2] = '{1,   640, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{15,  655, 0, 1, 1, 0, 0, 0};
    tbl[4] = '{1,   656, 0, 0, 1, 0, 0, 0};
    tbl[5] = '{95,  751, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{1,   752, 0, 1, 1, 0, 0, 0};
    tbl[7] = '{47,  799, 0, 1, 1, 0, 0, 0};
    tbl[8] = '{1,   0,   1, 1, 1, 1, 1, 0};
    tbl[9] = '{1,   1,   1, 1, 1, 1, 0, 0};

    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; ecnt[i] = 0; nt[i] = 0; jt[i] = 1'b0;
    end

    @(negedge clk);
    repeat (3) step(1'b1, '1);

    for (int k = 0; k < 10; k++) begin
      repeat (tbl[k].adv) step(1'b0, '1);
      a = sample(0);
      check_int("tbl_hc", k, a.hc, tbl[k].hc);
      check_int("tbl_vc", k, a.vc, tbl[k].vc);
      check_int("tbl_hsync", k, a.hs, tbl[k].hs);
      check_int("tbl_vsync", k, a.vs, tbl[k].vs);
      check_int("tbl_vidon", k, a.vid, tbl[k].vid);
      check_int("tbl_line_start", k, a.ls, tbl[k].ls);
      check_int("tbl_frame_start", k, a.fs, tbl[k].fs);
    end

    // en low for 17 clocks while u0 sits at hc=300
    guard = 0;
    while (expect_obs(0).hc != 300 && guard < 2000) begin
      step(1'b0, '1);
      guard++;
    end
    check_int("reach_hc300", 0, sample(0).hc, 300);
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 4'b1110);
      check_int("hold_hc", 0, sample(0).hc, 300);
      check_int("hold_tick", 0, int'(tk[0]), 0);
    end
    step(1'b0, '1);
    check_int("resume_hc", 0, sample(0).hc, 301);

    // clr pulse while u0 is at hc=700
    guard = 0;
    while (expect_obs(0).hc != 700 && guard < 2000) begin
      step(1'b0, '1);
      guard++;
    end
    check_int("reach_hc700", 0, sample(0).hc, 700);
    step(1'b1, '1);
    a = sample(0);
    check_int("clr_hc", 0, a.hc, 0);
    check_int("clr_hsync", 0, a.hs, 1);
    check_int("clr_vidon", 0, a.vid, 0);
    step(1'b1, '1);
    step(1'b0, '1);
    a = sample(0);
    check_int("post_clr_hc", 0, a.hc, 0);
    check_int("post_clr_vc", 0, a.vc, 0);
    check_int("post_clr_vidon", 0, a.vid, 1);
    check_int("post_clr_frame_start", 0, a.fs, 1);

    // random enables with occasional resets, all units against the model
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < N; i++) er[i] = ($urandom_range(0, 4) != 0);
      step($urandom_range(0, 2999) == 0, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
